// File: rtl/map_read_arbiter.sv
// Round-robin arbiter sharing the map ROM collision-read port between requesters.
// Every read is tagged with its issuer so the pixel returns to that requester after READ_LATENCY edges.
module map_read_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*10-1:0]   req_col,
    input  logic [NUM_REQ*10-1:0]   req_row,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [9:0]              map_col_addr,
    output logic [9:0]              map_row_addr,
    input  logic [7:0]              map_px,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [7:0]              rsp_data,
    output logic                    busy
);

    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned PX_W   = 8;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         win_id;
    logic                    win_vld;
    logic [ADDR_W-1:0]       col_arr [NUM_REQ];
    logic [ADDR_W-1:0]       row_arr [NUM_REQ];
    logic [ADDR_W-1:0]       col_q, col_d;
    logic [ADDR_W-1:0]       row_q, row_d;
    tag_t [READ_LATENCY-1:0] tag_q, tag_d;
    tag_t                    tag_last;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [PX_W-1:0]         rsp_data_q, rsp_data_d;

    // Unpack the flat per-requester address buses.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            col_arr[k] = req_col[k*ADDR_W +: ADDR_W];
            row_arr[k] = req_row[k*ADDR_W +: ADDR_W];
        end
    end

    // Search from ptr upward, wrapping; first pending request wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        gnt     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_vld && req[ID_W'(idx)]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
        if (win_vld) begin
            gnt[win_id] = 1'b1;
        end
    end

    assign tag_last = tag_q[READ_LATENCY-1];

    always_comb begin
        ptr_d       = ptr_q;
        col_d       = col_q;
        row_d       = row_q;
        tag_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (win_vld) begin
            ptr_d = (32'(win_id) == NUM_REQ - 1) ? '0 : win_id + ID_W'(1);
            col_d = col_arr[win_id];
            row_d = row_arr[win_id];
        end
        tag_d[0].vld = win_vld;
        tag_d[0].id  = win_id;
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        if (tag_last.vld) begin
            rsp_valid_d[tag_last.id] = 1'b1;
            rsp_data_d               = map_px;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s < READ_LATENCY; s++) begin
            busy = busy | tag_q[s].vld;
        end
    end

    assign map_col_addr = col_q;
    assign map_row_addr = row_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

endmodule
